// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: datapath widths, the NOP encoding and the
// {pc, inst} record carried between fetch and decode.
package mips_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with early stall (one skid slot for the
// in-flight fetch), synchronous flush and a sticky overflow flag.
module fetch_queue #(
  parameter int unsigned                      DEPTH    = 4,
  parameter logic [mips_pkg::INST_W-1:0]      NOP_INST = mips_pkg::NOP_INST
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                in_valid,
  input  logic [mips_pkg::ADDR_W-1:0]         in_pc,
  input  logic [mips_pkg::INST_W-1:0]         in_inst,
  output logic                                stall_out,
  output logic                                out_valid,
  output logic [mips_pkg::ADDR_W-1:0]         out_pc,
  output logic [mips_pkg::INST_W-1:0]         out_inst,
  input  logic                                out_ready,
  input  logic                                flush,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                overflow
);

  import mips_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               full, empty, push, pop;

  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    pop   = ~empty & out_ready & ~flush;
    push  = in_valid & ~flush & (~full | pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid & ~flush & full & ~pop);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so wrap is the natural rollover.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, inst: in_inst};
  end

  always_comb begin
    head      = mem_q[rd_ptr_q];
    out_valid = ~empty;
    out_pc    = empty ? '0 : head.pc;
    out_inst  = empty ? NOP_INST : head.inst;
    stall_out = (count_q >= FULL_CNT - CNT_W'(1));
    count     = count_q;
    overflow  = overflow_q;
  end

endmodule
